// File: rtl/predistort_tap_loader.sv
// Settings-bus tap loader for the predistort block: queues coefficient writes into each
// channel's shadow bank and swaps a channel's active bank on commit, at a packet boundary.
module predistort_tap_loader #(
    parameter int         NUM_CHANNELS  = 4,
    parameter int         TAP_AW        = 8,
    parameter int         FIFO_AW       = 4,
    parameter logic [7:0] SR_WHICH_TAPS = 8'd192,
    parameter logic [7:0] SR_TAP_DATA   = 8'd193,
    parameter logic [7:0] SR_TAP_COMMIT = 8'd194
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    set_stb,
    input  logic [7:0]              set_addr,
    input  logic [31:0]             set_data,
    output logic [NUM_CHANNELS-1:0] tap_we,
    output logic                    tap_bank,
    output logic [TAP_AW-1:0]       tap_addr,
    output logic [31:0]             tap_data,
    input  logic                    tap_ready,
    input  logic [NUM_CHANNELS-1:0] frame_done,
    input  logic [NUM_CHANNELS-1:0] chan_idle,
    output logic [NUM_CHANNELS-1:0] active_bank,
    output logic [NUM_CHANNELS-1:0] swap_pulse,
    output logic [31:0]             status
);
    localparam int                CW        = FIFO_AW + 1;
    localparam int                DEPTH_N   = 2 ** FIFO_AW;
    localparam logic [CW-1:0]     DEPTH     = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [TAP_AW-1:0] LAST_ADDR = {TAP_AW{1'b1}};

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DRAIN} commit_state_t;

    typedef struct packed {
        logic [1:0]        chan;
        logic [TAP_AW-1:0] addr;
        logic [31:0]       data;
    } entry_t;

    logic [1:0]              sel_q, sel_d;
    logic [TAP_AW-1:0]       wr_addr_q, wr_addr_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    ovf_q, ovf_d;
    entry_t                  mem_q [DEPTH_N];
    logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           mem_cnt_q, mem_cnt_d;
    entry_t                  out_q, out_d;
    logic [NUM_CHANNELS-1:0] tap_we_q, tap_we_d;
    logic                    tap_bank_q, tap_bank_d;
    logic [NUM_CHANNELS-1:0] active_bank_q, active_bank_d;
    logic [NUM_CHANNELS-1:0] swap_q, swap_d;
    commit_state_t           state_q [NUM_CHANNELS];
    commit_state_t           state_d [NUM_CHANNELS];
    logic [CW-1:0]           chan_cnt_q [NUM_CHANNELS];
    logic [CW-1:0]           chan_cnt_d [NUM_CHANNELS];

    logic                    wr_sel, wr_data, wr_commit, sel_valid;
    logic                    out_vld, pop, take, push, fifo_full;
    logic [NUM_CHANNELS-1:0] pending, commit_req;
    entry_t                  new_entry, head;
    logic [3:0]              pend_ext, ab_ext;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        sel_d      = sel_q;
        wr_addr_d  = wr_addr_q;
        done_d     = done_q;
        err_d      = err_q;
        ovf_d      = ovf_q;
        push       = 1'b0;
        commit_req = '0;
        new_entry  = '{chan: sel_q, addr: wr_addr_q, data: set_data};
        head       = mem_q[rd_ptr_q];

        wr_sel    = set_stb && (set_addr == SR_WHICH_TAPS);
        wr_data   = set_stb && (set_addr == SR_TAP_DATA);
        wr_commit = set_stb && (set_addr == SR_TAP_COMMIT);
        sel_valid = int'(sel_q) < NUM_CHANNELS;
        out_vld   = |tap_we_q;
        pop       = out_vld && tap_ready;
        take      = (mem_cnt_q != '0) && (!out_vld || tap_ready);
        fifo_full = (mem_cnt_q + CW'(out_vld)) == DEPTH;

        for (int k = 0; k < NUM_CHANNELS; k++) begin
            pending[k] = (state_q[k] != ST_IDLE);
        end

        if (wr_sel) begin
            sel_d     = set_data[1:0];
            wr_addr_d = '0;
            done_d    = 1'b0;
            if (set_data[31]) begin
                err_d = 1'b0;
                ovf_d = 1'b0;
            end
            if (int'(set_data[1:0]) >= NUM_CHANNELS) begin
                err_d = 1'b1;
            end
        end else if (wr_data && sel_valid) begin
            if (pending[sel_q] || done_q) begin
                err_d = 1'b1;
            end else if (fifo_full) begin
                ovf_d = 1'b1;
            end else begin
                push = 1'b1;
                if (wr_addr_q == LAST_ADDR) done_d = 1'b1;
                else                        wr_addr_d = wr_addr_q + TAP_AW'(1);
            end
        end else if (wr_commit && sel_valid) begin
            commit_req[sel_q] = 1'b1;
        end

        // Output stage is the FIFO head; it reloads from the queue as it is consumed.
        wr_ptr_d   = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d   = take ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        mem_cnt_d  = mem_cnt_q;
        if (push && !take)      mem_cnt_d = mem_cnt_q + CW'(1);
        else if (!push && take) mem_cnt_d = mem_cnt_q - CW'(1);
        out_d      = out_q;
        tap_we_d   = tap_we_q;
        tap_bank_d = tap_bank_q;
        if (take) begin
            out_d      = head;
            tap_bank_d = ~active_bank_q[head.chan];
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                tap_we_d[k] = (int'(head.chan) == k);
            end
        end else if (pop) begin
            tap_we_d = '0;
        end

        swap_d = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            chan_cnt_d[k] = chan_cnt_q[k];
            if ((push && int'(new_entry.chan) == k) && !(pop && tap_we_q[k]))
                chan_cnt_d[k] = chan_cnt_q[k] + CW'(1);
            else if (!(push && int'(new_entry.chan) == k) && (pop && tap_we_q[k]))
                chan_cnt_d[k] = chan_cnt_q[k] - CW'(1);

            state_d[k] = state_q[k];
            unique case (state_q[k])
                ST_IDLE:  if (commit_req[k]) state_d[k] = ST_PEND;
                ST_PEND:  if (chan_cnt_d[k] == '0) state_d[k] = ST_DRAIN;
                ST_DRAIN: if (frame_done[k] || chan_idle[k]) begin
                    swap_d[k]  = 1'b1;
                    state_d[k] = ST_IDLE;
                end
                default:  state_d[k] = ST_IDLE;
            endcase
            if (swap_d[k] && int'(sel_q) == k) begin
                wr_addr_d = '0;
                done_d    = 1'b0;
            end
        end
        active_bank_d = active_bank_q ^ swap_d;

        pend_ext = '0;
        ab_ext   = '0;
        pend_ext[NUM_CHANNELS-1:0] = pending;
        ab_ext[NUM_CHANNELS-1:0]   = active_bank_q;
        status                     = '0;
        status[31]                 = ovf_q;
        status[30]                 = err_q;
        status[29:26]              = pend_ext;
        status[25:24]              = sel_q;
        status[23:20]              = ab_ext;
        status[TAP_AW-1:0]         = wr_addr_q;
    end

    // NOTE: queue storage has no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= new_entry;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q         <= '0;
            wr_addr_q     <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            ovf_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_cnt_q     <= '0;
            out_q         <= '0;
            tap_we_q      <= '0;
            tap_bank_q    <= 1'b0;
            active_bank_q <= '0;
            swap_q        <= '0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                state_q[k]    <= ST_IDLE;
                chan_cnt_q[k] <= '0;
            end
        end else begin
            sel_q         <= sel_d;
            wr_addr_q     <= wr_addr_d;
            done_q        <= done_d;
            err_q         <= err_d;
            ovf_q         <= ovf_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_cnt_q     <= mem_cnt_d;
            out_q         <= out_d;
            tap_we_q      <= tap_we_d;
            tap_bank_q    <= tap_bank_d;
            active_bank_q <= active_bank_d;
            swap_q        <= swap_d;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                state_q[k]    <= state_d[k];
                chan_cnt_q[k] <= chan_cnt_d[k];
            end
        end
    end

    assign tap_we      = tap_we_q;
    assign tap_bank    = tap_bank_q;
    assign tap_addr    = out_q.addr;
    assign tap_data    = out_q.data;
    assign active_bank = active_bank_q;
    assign swap_pulse  = swap_q;

endmodule

// File: tb/tb_predistort_tap_loader.sv
// Directed bench for predistort_tap_loader: a default instance plus a TAP_AW=2 instance
// sharing the settings bus, used for address saturation.
module tb_predistort_tap_loader;
    localparam logic [7:0] SR_WHICH  = 8'd192;
    localparam logic [7:0] SR_DATA   = 8'd193;
    localparam logic [7:0] SR_COMMIT = 8'd194;

    typedef struct packed {
        logic [3:0]  we;
        logic        bank;
        logic [7:0]  addr;
        logic [31:0] data;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic        tap_ready = 1'b0;
    logic [3:0]  frame_done = '0;
    logic [3:0]  chan_idle = '0;

    logic [3:0]  tap_we, active_bank, swap_pulse;
    logic        tap_bank;
    logic [7:0]  tap_addr;
    logic [31:0] tap_data, status;

    logic [3:0]  tap_we2, active_bank2, swap_pulse2;
    logic        tap_bank2;
    logic [1:0]  tap_addr2;
    logic [31:0] tap_data2, status2;

    rec_t        log_q[$];
    logic [33:0] log2_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    predistort_tap_loader dut (
        .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .tap_we(tap_we), .tap_bank(tap_bank), .tap_addr(tap_addr), .tap_data(tap_data),
        .tap_ready(tap_ready), .frame_done(frame_done), .chan_idle(chan_idle),
        .active_bank(active_bank), .swap_pulse(swap_pulse), .status(status)
    );

    predistort_tap_loader #(.TAP_AW(2)) dut_small (
        .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .tap_we(tap_we2), .tap_bank(tap_bank2), .tap_addr(tap_addr2), .tap_data(tap_data2),
        .tap_ready(tap_ready), .frame_done(frame_done), .chan_idle(chan_idle),
        .active_bank(active_bank2), .swap_pulse(swap_pulse2), .status(status2)
    );

    always #5 clk = ~clk;

    // Record every accepted tap write, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && tap_ready && |tap_we)  log_q.push_back('{tap_we, tap_bank, tap_addr, tap_data});
        if (!reset && tap_ready && |tap_we2) log2_q.push_back({tap_addr2, tap_data2});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sr_write(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        tick();
        set_stb  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    rec_t exp_r;
    int   n_swaps;

    initial begin
        // Reset state and basic load into channel 2
        do_reset();
        tap_ready = 1'b1;
        check("rst_we", tap_we, 4'b0000);
        check("rst_active_bank", active_bank, 4'b0000);
        check("rst_status", status, 32'h0);
        check("rst_tap_fields", {swap_pulse, tap_bank, tap_addr, tap_data}, 0);
        sr_write(SR_WHICH, 32'd2);
        log_q.delete();
        sr_write(SR_DATA, 32'h11);
        check("lat1_we", tap_we, 4'b0000);
        sr_write(SR_DATA, 32'h22);
        check("lat2_we", tap_we, 4'b0100);
        check("lat2_bank_addr_data", {tap_bank, tap_addr, tap_data}, {1'b1, 8'd0, 32'h11});
        sr_write(SR_DATA, 32'h33);
        sr_write(SR_DATA, 32'h44);
        repeat (4) tick();
        check("load_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            exp_r = '{4'b0100, 1'b1, 8'(i), 32'h11 * 32'(i + 1)};
            check($sformatf("load_rec%0d", i), log_q[i], exp_r);
        end
        check("load_status", status, 32'h0200_0004);

        // Backpressure: outputs hold while tap_ready is low, nothing lost afterwards
        tap_ready = 1'b0;
        log_q.delete();
        sr_write(SR_DATA, 32'hA1);
        sr_write(SR_DATA, 32'hA2);
        sr_write(SR_DATA, 32'hA3);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp_hold%0d", i), {tap_we, tap_bank, tap_addr, tap_data},
                  {4'b0100, 1'b1, 8'd4, 32'hA1});
        end
        check("bp_no_accept", log_q.size(), 0);
        tap_ready = 1'b1;
        repeat (5) tick();
        check("bp_count", log_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            exp_r = '{4'b0100, 1'b1, 8'(4 + i), 32'hA1 + 32'(i)};
            check($sformatf("bp_rec%0d", i), log_q[i], exp_r);
        end

        // Overflow with a 16-deep queue
        do_reset();
        tap_ready = 1'b0;
        sr_write(SR_WHICH, 32'd1);
        log_q.delete();
        for (int i = 0; i < 17; i++) sr_write(SR_DATA, 32'(i));
        check("ovf_status", status, 32'h8100_0010);
        sr_write(SR_WHICH, 32'h8000_0001);
        check("ovf_clear_status", status, 32'h0100_0000);
        tap_ready = 1'b1;
        repeat (20) tick();
        check("ovf_count", log_q.size(), 16);
        check("ovf_first", log_q[0], {4'b0010, 1'b1, 8'd0, 32'd0});
        check("ovf_last", log_q[15], {4'b0010, 1'b1, 8'd15, 32'd15});

        // Commit gating on a busy channel
        do_reset();
        tap_ready = 1'b1;
        sr_write(SR_WHICH, 32'd1);
        sr_write(SR_COMMIT, 32'd0);
        repeat (5) tick();
        check("gate_no_swap", active_bank, 4'b0000);
        check("gate_status_pend", status, 32'h0900_0000);
        log_q.delete();
        sr_write(SR_DATA, 32'h55);
        check("gate_err_status", status, 32'h4900_0000);
        repeat (3) tick();
        check("gate_write_dropped", log_q.size(), 0);
        frame_done = 4'b0010;
        tick();
        frame_done = 4'b0000;
        check("gate_swap_bank", active_bank, 4'b0010);
        check("gate_swap_pulse", swap_pulse, 4'b0010);
        tick();
        check("gate_pulse_end", swap_pulse, 4'b0000);
        check("gate_status_after", status, 32'h4120_0000);
        sr_write(SR_WHICH, 32'h8000_0001);
        check("gate_err_clear", status, 32'h0120_0000);
        chan_idle  = 4'b0010;
        frame_done = 4'b0010;
        sr_write(SR_COMMIT, 32'd0);
        n_swaps = 0;
        repeat (6) begin
            tick();
            if (swap_pulse[1]) n_swaps++;
        end
        frame_done = 4'b0000;
        chan_idle  = 4'b0000;
        check("dual_swap_count", n_swaps, 1);
        check("dual_swap_bank", active_bank, 4'b0000);

        // Commit waits for queued writes of its channel
        do_reset();
        tap_ready = 1'b0;
        chan_idle = 4'b1111;
        sr_write(SR_WHICH, 32'd0);
        sr_write(SR_DATA, 32'hB1);
        sr_write(SR_DATA, 32'hB2);
        sr_write(SR_DATA, 32'hB3);
        sr_write(SR_COMMIT, 32'd0);
        repeat (3) tick();
        check("drain_no_swap", active_bank, 4'b0000);
        check("drain_status_pend", status, 32'h0400_0003);
        log_q.delete();
        tap_ready = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            check($sformatf("drain_bank_t%0d", t), active_bank, (t == 4) ? 4'b0001 : 4'b0000);
        end
        check("drain_pulse", swap_pulse, 4'b0001);
        check("drain_count", log_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            exp_r = '{4'b0001, 1'b1, 8'(i), 32'hB1 + 32'(i)};
            check($sformatf("drain_rec%0d", i), log_q[i], exp_r);
        end
        check("drain_status_after", status, 32'h0010_0000);
        chan_idle = 4'b0000;

        // Address saturation on the 4-tap instance
        do_reset();
        tap_ready = 1'b1;
        sr_write(SR_WHICH, 32'd3);
        log2_q.delete();
        for (int i = 0; i < 5; i++) sr_write(SR_DATA, 32'hC0 + 32'(i));
        repeat (4) tick();
        check("sat_count", log2_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sat_rec%0d", i), log2_q[i], {2'(i), 32'hC0 + 32'(i)});
        end
        check("sat_status", status2, 32'h4300_0003);

        // Reset with writes queued and a swapped bank
        do_reset();
        chan_idle = 4'b1111;
        tap_ready = 1'b0;
        sr_write(SR_WHICH, 32'd2);
        sr_write(SR_COMMIT, 32'd0);
        repeat (3) tick();
        check("pre_rst_bank", active_bank, 4'b0100);
        sr_write(SR_DATA, 32'hD0);
        sr_write(SR_DATA, 32'hD1);
        sr_write(SR_DATA, 32'hD2);
        tick();
        check("pre_rst_head", {tap_we, tap_bank, tap_addr, tap_data}, {4'b0100, 1'b0, 8'd0, 32'hD0});
        reset = 1'b1;
        tick();
        check("rst_mid_we", tap_we, 4'b0000);
        check("rst_mid_bank", active_bank, 4'b0000);
        check("rst_mid_status", status, 32'h0);
        reset = 1'b0;
        chan_idle = 4'b0000;
        tap_ready = 1'b1;
        log_q.delete();
        repeat (4) tick();
        check("rst_queue_discarded", log_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/predistort_tap_loader.md
Name: predistort_tap_loader

Overview:
- Settings-bus controller that loads coefficient taps into the NUM_CHANNELS predistorter instances of the predistort NoC block.
- Each predistorter has double-buffered (bank 0/1) tap RAM. This block holds the active bank per channel and sequences every tap write into the shadow bank.
- On a commit it swaps banks, but only at a packet boundary of that channel, so a packet never mixes coefficient sets.
- It sits between the noc_shell settings bus and the per-channel predistorter tap ports.

Parameters:
- NUM_CHANNELS, 4, number of predistorter channels (1..4).
- TAP_AW, 8, tap address width; NUM_TAPS = 2**TAP_AW.
- FIFO_AW, 4, write-queue depth = 2**FIFO_AW entries.
- SR_WHICH_TAPS, 192, channel-select register address.
- SR_TAP_DATA, 193, tap-data register address.
- SR_TAP_COMMIT, 194, commit register address.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- set_stb  in  1  settings strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- tap_we  out  NUM_CHANNELS  per-channel tap write strobe (one-hot)
- tap_bank  out  1  bank written (shadow bank of target channel)
- tap_addr  out  TAP_AW  tap write address
- tap_data  out  32  tap value
- tap_ready  in  1  shared tap port accepts a write this cycle
- frame_done  in  NUM_CHANNELS  pulse on the last beat of a channel's packet (tvalid&tready&tlast)
- chan_idle  in  NUM_CHANNELS  channel has no packet in flight
- active_bank  out  NUM_CHANNELS  bank used by each predistorter
- swap_pulse  out  NUM_CHANNELS  one-cycle pulse when a channel swaps banks
- status  out  32  readback word

Behaviour:
- Reset values: tap_we=0, tap_bank=0, tap_addr=0, tap_data=0, active_bank=0, swap_pulse=0, status=0. Reset also clears sel, wr_addr, FIFO, pending, overflow and err.
- SR_WHICH_TAPS write:
  - sel <= set_data[1:0] and wr_addr <= 0.
  - If sel >= NUM_CHANNELS, set err; later data writes are dropped until a valid sel is written.
- SR_TAP_DATA write:
  - If the FIFO is not full and no commit is pending on sel, enqueue {sel, wr_addr, set_data} and then increment wr_addr.
  - When wr_addr = NUM_TAPS-1 the write is accepted and wr_addr saturates there (done flag set). Any further write is dropped and sets err.
  - A write to a full FIFO is dropped and sets the sticky overflow flag; wr_addr is not incremented.
  - A write while pending[sel]=1 is dropped and sets err.
- FIFO is first-word fall-through.
  - Head is presented on tap_* with tap_we[head.chan]=1 and tap_bank = ~active_bank[head.chan], all registered.
  - An entry is popped on a cycle with tap_we!=0 and tap_ready=1. Outputs stay stable while tap_ready=0.
  - Throughput is 1 write/cycle. Latency from set_stb to tap_we is 2 cycles when the FIFO is empty.
  - Enqueue and dequeue in the same cycle are both honoured; the count is unchanged.
- SR_TAP_COMMIT write (data ignored) sets pending[sel]. If pending[sel] is already set, the write is a no-op.
- Per-channel commit FSM:
  - IDLE -> PEND on commit.
  - PEND -> DRAIN when no FIFO entry targets this channel.
  - DRAIN -> swap when frame_done[k] | chan_idle[k]. On that cycle toggle active_bank[k], pulse swap_pulse[k], clear pending[k], reset wr_addr to 0 if sel==k, then return to IDLE.
  - frame_done and chan_idle asserted together cause a single swap.
  - Different channels may swap in the same cycle.
- Arbitration: the shared tap port is strictly FIFO-ordered; there is no per-channel reordering.
- status layout: [31] overflow, [30] err, [29:26] pending (zero-extended), [25:24] sel, [23:20] active_bank, [19:TAP_AW] 0, [TAP_AW-1:0] wr_addr.
- SR_WHICH_TAPS with set_data[31]=1 clears overflow and err.
- Reset mid-operation discards queued writes. Banks return to 0 regardless of in-flight loads.

Test Plan:
- Load: sel=2, then 4 data writes 0x11..0x44 with tap_ready=1 -> tap_we=4'b0100, tap_bank=1, addr 0..3 carry data 0x11..0x44 in order, first tap_we 2 cycles after the first strobe.
- Backpressure: tap_ready=0 for 10 cycles while writing 3 taps -> tap_* held constant; all 3 taps delivered in order after release; no loss.
- Overflow: FIFO_AW=4, tap_ready=0, 17 data writes -> 16 queued, status[31]=1, wr_addr=16. Writing SR_WHICH_TAPS with bit31=1 clears the flag.
- Commit gating: commit ch1 while ch1 mid-packet (chan_idle=0) -> no swap until frame_done[1]. Swap occurs on that exact cycle: active_bank[1]=1, swap_pulse[1] high one cycle. A data write to ch1 while pending sets err and is dropped.
- Commit with pending FIFO entries: 3 queued ch0 writes, tap_ready=0, chan_idle=1 -> no swap until the last ch0 entry pops. The swap follows 1 cycle later, and all 3 writes used bank 1.
- Saturation/wrap and reset: TAP_AW=2, 5 writes -> addrs 0,1,2,3 written, 5th dropped, err=1. Assert reset with entries queued -> tap_we=0, active_bank=0, status=0 next cycle.
